adc_sample_sched: RTL



---
 rtl/adc_sched_pkg.sv | 20 ++
 rtl/period_tick_gen.sv | 39 +++
 rtl/adc_sample_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types and helpers for the ADC sampling sequencer.
// Holds the state encoding, datapath widths and the saturating counter increment.
package adc_sched_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CONV,
    SEND,
    WAIT
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/period_tick_gen.sv
// Free-running 0..PERIOD-1 counter with clear and enable; tick marks the last count.
// Kept generic so the UART baud and FND scan logic can reuse it.
module period_tick_gen #(
  parameter int PERIOD   = 1000,
  parameter int PERIOD_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PERIOD_W-1:0] LAST = PERIOD_W'(PERIOD - 1);

  logic [PERIOD_W-1:0] cnt_reg;
  logic [PERIOD_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // The counter freezes while disabled, so gate tick to avoid a stale pulse.
  assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/adc_sample_sched.sv
// Sequencer for ADC read -> display latch -> UART hand-off, paced by a period tick.
// Tracks overruns (ticks that arrive while a sample is still in flight) and ADC timeouts.
module adc_sample_sched
  import adc_sched_pkg::*;
#(
  parameter int PERIOD      = 1000,
  parameter int PERIOD_W    = 16,
  parameter int ADC_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              single,
  input  logic              adc_busy,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              tx_busy,
  output logic              adc_req,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] disp_data,
  output logic              running,
  output logic [CNT_W-1:0]  overrun_cnt,
  output logic [CNT_W-1:0]  timeout_cnt
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ADC_TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
  logic                single_reg, single_next;
  logic                adc_req_reg, adc_req_next;
  logic                tx_req_reg, tx_req_next;
  logic [DATA_W-1:0]   tx_data_reg, tx_data_next;
  logic [DATA_W-1:0]   disp_reg, disp_next;
  logic                running_reg, running_next;
  logic [CNT_W-1:0]    overrun_reg, overrun_next;
  logic [CNT_W-1:0]    timeout_reg, timeout_next;

  logic tick;
  logic tick_clr;
  logic tick_en;

  assign tick_clr = (state_reg == IDLE) && start && !stop;
  assign tick_en  = (state_reg != IDLE);

  period_tick_gen #(
    .PERIOD   (PERIOD),
    .PERIOD_W (PERIOD_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    state_next   = state_reg;
    to_cnt_next  = '0;
    single_next  = single_reg;
    adc_req_next = 1'b0;
    tx_req_next  = 1'b0;
    tx_data_next = tx_data_reg;
    disp_next    = disp_reg;
    overrun_next = overrun_reg;
    timeout_next = timeout_reg;

    // stop beats everything, including any request that would issue this edge
    if (stop && (state_reg != IDLE)) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && !stop) begin
            state_next   = REQ;
            single_next  = single;
            overrun_next = '0;
            timeout_next = '0;
          end
        end
        REQ: begin
          if (!adc_busy) begin
            state_next   = CONV;
            adc_req_next = 1'b1;
          end
        end
        CONV: begin
          if (adc_done) begin
            state_next   = SEND;
            disp_next    = adc_data;
            tx_data_next = adc_data;
          end else if (to_cnt_reg == TO_LAST) begin
            state_next   = single_reg ? IDLE : WAIT;
            timeout_next = sat_inc(timeout_reg);
          end else begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
          end
        end
        SEND: begin
          if (!tx_busy) begin
            state_next  = single_reg ? IDLE : WAIT;
            tx_req_next = 1'b1;
          end
        end
        WAIT: begin
          if (tick) begin
            state_next = REQ;
          end
        end
        default: state_next = IDLE;
      endcase

      // A tick outside WAIT is dropped, never queued.
      if (tick && ((state_reg == REQ) || (state_reg == CONV) || (state_reg == SEND))) begin
        overrun_next = sat_inc(overrun_reg);
      end
    end

    running_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      to_cnt_reg  <= '0;
      single_reg  <= 1'b0;
      adc_req_reg <= 1'b0;
      tx_req_reg  <= 1'b0;
      tx_data_reg <= '0;
      disp_reg    <= '0;
      running_reg <= 1'b0;
      overrun_reg <= '0;
      timeout_reg <= '0;
    end else begin
      state_reg   <= state_next;
      to_cnt_reg  <= to_cnt_next;
      single_reg  <= single_next;
      adc_req_reg <= adc_req_next;
      tx_req_reg  <= tx_req_next;
      tx_data_reg <= tx_data_next;
      disp_reg    <= disp_next;
      running_reg <= running_next;
      overrun_reg <= overrun_next;
      timeout_reg <= timeout_next;
    end
  end

  assign adc_req     = adc_req_reg;
  assign tx_req      = tx_req_reg;
  assign tx_data     = tx_data_reg;
  assign disp_data   = disp_reg;
  assign running     = running_reg;
  assign overrun_cnt = overrun_reg;
  assign timeout_cnt = timeout_reg;

endmodule
